// File: rtl/spi_master_engine.sv
// SPI mode-0 master shift engine: streams TX buffer bytes MSB first and writes MISO bytes to the RX buffer.
// Optional build macro SPI_LOOPBACK_EN samples the driven mosi instead of the miso pin.
module spi_master_engine #(
  parameter int N       = 5,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         send,
  input  logic         cs_ctrl,
  input  logic         all_1s,
  input  logic         all_0s,
  input  logic [N:0]   n_tx_end,
  input  logic [7:0]   tx_data,
  output logic [N+1:0] tx_addr,
  output logic [7:0]   rx_data,
  output logic [N+1:0] rx_addr,
  output logic         rx_we,
  output logic         send_sign,
  output logic         hold_ctrl,
  output logic [N+1:0] n_rx_end,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         cs
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

  localparam int            HW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HP_LAST = HW'(CLK_DIV - 1);

  state_t        state;
  logic [N+1:0]  byte_idx;
  logic [N:0]    n_end;
  logic          f1s, f0s;
  logic [7:0]    tx_sh, rx_sh, load_byte;
  logic [HW-1:0] hp_cnt;
  logic [2:0]    bit_cnt;
  logic          sample_bit;

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = mosi;
`else
  assign sample_bit = miso;
`endif

  assign tx_addr = byte_idx;
  assign cs      = ~((state != IDLE) | cs_ctrl);

  always_comb begin
    load_byte = tx_data;
    if (f1s)      load_byte = 8'hFF;
    else if (f0s) load_byte = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      byte_idx  <= '0;
      n_end     <= '0;
      f1s       <= 1'b0;
      f0s       <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      hp_cnt    <= '0;
      bit_cnt   <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      rx_we     <= 1'b0;
      rx_addr   <= '0;
      rx_data   <= '0;
      send_sign <= 1'b0;
      hold_ctrl <= 1'b0;
      n_rx_end  <= '0;
    end else begin
      rx_we     <= 1'b0;
      hold_ctrl <= 1'b0;
      send_sign <= 1'b0;
      case (state)
        IDLE: if (send) begin
          state    <= LOAD;
          byte_idx <= '0;
          n_rx_end <= '0;
          n_end    <= n_tx_end;
          f1s      <= all_1s;
          f0s      <= all_0s;
        end
        LOAD: begin
          tx_sh   <= load_byte;
          mosi    <= load_byte[7];
          hp_cnt  <= '0;
          bit_cnt <= '0;
          sclk    <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (hp_cnt == HP_LAST) begin
            hp_cnt <= '0;
            sclk   <= ~sclk;
            if (!sclk) begin
              rx_sh <= {rx_sh[6:0], sample_bit};
            end else begin
              tx_sh   <= {tx_sh[6:0], 1'b0};
              mosi    <= tx_sh[6];
              bit_cnt <= bit_cnt + 3'd1;
              // Strobes are set on entry so they are high exactly during STORE.
              if (bit_cnt == 3'd7) begin
                state     <= STORE;
                rx_we     <= 1'b1;
                rx_addr   <= byte_idx;
                rx_data   <= rx_sh;
                hold_ctrl <= 1'b1;
                n_rx_end  <= byte_idx + 1'b1;
              end
            end
          end else begin
            hp_cnt <= hp_cnt + 1'b1;
          end
        end
        STORE: begin
          if (byte_idx == {1'b0, n_end}) begin
            state     <= DONE;
            send_sign <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            state    <= LOAD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_engine.md
Name: spi_master_engine

Overview:
- Serial shift engine directly downstream of the SPI control register.
- Consumes send/cs_ctrl/all_1s/all_0s/n_tx_end, reads TX bytes from the TX buffer, and drives SCLK/MOSI/CS (SPI mode 0, MSB first).
- Writes each received MISO byte into the RX buffer.
- Returns send_sign (clear send), hold_ctrl and n_rx_end to the control register.

Parameters:
- N, 5, width selector; n_tx_end is N+1 bits, n_rx_end and buffer addresses N+2 bits; N<=11.
- CLK_DIV, 4, system clocks per SCLK half-period; must be >=1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- send  input  1  start request from control register bit 0.
- cs_ctrl  input  1  manual chip-select hold from control register bit 1.
- all_1s  input  1  transmit 8'hFF instead of buffer data.
- all_0s  input  1  transmit 8'h00 instead of buffer data.
- n_tx_end  input  N+1  index of the last byte; transfer length = n_tx_end+1.
- tx_data  input  8  TX buffer read data, combinational from tx_addr.
- tx_addr  output  N+2  TX buffer read address.
- rx_data  output  8  RX buffer write data.
- rx_addr  output  N+2  RX buffer write address.
- rx_we  output  1  RX buffer write strobe, one cycle.
- send_sign  output  1  one-cycle pulse that clears send.
- hold_ctrl  output  1  one-cycle pulse that loads n_rx_end into the control register.
- n_rx_end  output  N+2  count of bytes received in the current/last transfer.
- sclk  output  1  SPI clock, idle low.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in.
- cs  output  1  chip select, active low.

Behaviour:
- Reset (rst==0 at a clk edge), including mid-transfer: FSM returns to IDLE. Outputs take these values: sclk=0, mosi=0, cs=1, rx_we=0, send_sign=0, hold_ctrl=0, tx_addr=0, rx_addr=0, rx_data=0, n_rx_end=0. Any partial byte is discarded.
- cs: low whenever FSM != IDLE or cs_ctrl==1; high otherwise.
- FSM states: IDLE, LOAD, SHIFT, STORE, DONE.
- IDLE
  - send==1 -> LOAD. Also clears byte_idx=0 and n_rx_end=0.
  - send==0 -> stay in IDLE.
- LOAD
  - Latches the TX byte with priority all_1s > all_0s > tx_data at tx_addr=byte_idx.
  - Drives mosi = byte bit 7 and clears the half-period counter and bit counter.
  - Next state: SHIFT.
- SHIFT
  - Half-period counter counts 0..CLK_DIV-1; sclk toggles on wrap.
  - Rising sclk: sample miso into rx shift register LSB.
  - Falling sclk: shift TX byte left and drive the next bit on mosi.
  - After the 8th falling edge -> STORE. SCLK spends exactly CLK_DIV clocks in each level.
- STORE (one cycle)
  - rx_we=1, rx_addr=byte_idx, rx_data=assembled byte.
  - hold_ctrl=1 with n_rx_end already equal to byte_idx+1.
  - If byte_idx==n_tx_end -> DONE; else byte_idx+1 and -> LOAD.
- DONE (one cycle)
  - send_sign=1, then -> IDLE.
  - The control register clears send on the same edge, so IDLE does not restart.
- Inputs are sampled only in IDLE/LOAD.
  - n_tx_end, all_1s and all_0s are captured in IDLE on the start edge and held for the whole transfer.
  - send dropping mid-transfer is ignored; the transfer completes.
- Boundaries
  - n_tx_end=0 gives 1 byte.
  - n_tx_end=2^(N+1)-1 gives 2^(N+1) bytes; n_rx_end reaches 2^(N+1) without overflow (N+2 bits).
- Per-byte time = 1 (LOAD) + 16*CLK_DIV (SHIFT) + 1 (STORE). Add 1 DONE cycle per transfer.
- The byte gap gives an extra sclk-low period of 2 clocks between bytes; cs stays low across bytes.

Optional Feature:
- SPI_LOOPBACK_EN defined:
  - The rising-edge sample uses the internally driven mosi instead of the miso pin, so RX bytes equal TX bytes.
  - The miso port remains but is ignored.
- Not defined: miso is sampled as specified.

Test Plan:
- CLK_DIV=2, n_tx_end=0, tx_data=8'hA5, miso tied to 8'h3C pattern, send=1
  - mosi bits 1,0,1,0,0,1,0,1 on 8 rising edges.
  - rx_we once with rx_addr=0, rx_data=8'h3C.
  - hold_ctrl with n_rx_end=1, then send_sign one cycle later.
  - sclk high exactly 2 clocks per pulse.
- n_tx_end=3, buffer 11,22,33,44
  - tx_addr steps 0..3 and rx_we at rx_addr 0..3.
  - n_rx_end reports 1,2,3,4.
  - cs low continuously from LOAD through DONE.
- all_1s=1 with all_0s=1, tx_data=8'h00 -> mosi high for all 8 bits (all_1s priority). Repeat with all_0s only -> mosi low throughout.
- rst driven low during bit 4 of byte 1
  - Next edge: sclk=0, cs=1, n_rx_end=0, no rx_we.
  - After release with send=1, a fresh transfer starts at tx_addr=0.
- cs_ctrl=1 with send=0 -> cs=0 and sclk static 0. With send dropped to 0 mid-transfer -> transfer still completes all n_tx_end+1 bytes.
- SPI_LOOPBACK_EN defined, n_tx_end=1, bytes 8'h5A, 8'hC3, miso tied 0 -> rx_data 8'h5A then 8'hC3.
